// File: rtl/vcve2_vinstr_dispatch.sv
// vcve2_vinstr_dispatch: in-order offload queue from the ID stage to the external vector unit
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   id_valid_i/id_ready_o           ID handshake carrying id_instr_i, id_rs1_i, id_rs2_i, id_wb_i
//   illegal_o                       pulse after a non-vector opcode is presented
//   flush_i                         drops every un-issued FIFO entry
//   vu_req_valid_o/vu_req_ready_i   request channel carrying vu_instr_o, vu_rs1_o, vu_rs2_o
//   vu_rsp_valid_i                  in-order response with vu_rsp_data_i, vu_rsp_err_i
//   wb_valid_o, wb_rd_o, wb_data_o  scalar regfile write
//   wb_err_o                        error response pulse
//   busy_o, proto_err_o             activity flag, sticky unexpected-response flag
module vcve2_vinstr_dispatch #(
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_valid_i,
    output logic        id_ready_o,
    input  logic [31:0] id_instr_i,
    input  logic [31:0] id_rs1_i,
    input  logic [31:0] id_rs2_i,
    input  logic        id_wb_i,
    output logic        illegal_o,
    input  logic        flush_i,
    output logic        vu_req_valid_o,
    input  logic        vu_req_ready_i,
    output logic [31:0] vu_instr_o,
    output logic [31:0] vu_rs1_o,
    output logic [31:0] vu_rs2_o,
    input  logic        vu_rsp_valid_i,
    input  logic [31:0] vu_rsp_data_i,
    input  logic        vu_rsp_err_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_err_o,
    output logic        busy_o,
    output logic        proto_err_o
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int TW  = $clog2(MAX_OUTST);
    localparam int TCW = TW + 1;
    typedef enum logic {IDLE, WB_WAIT} state_e;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        wb;
    } fifo_t;
    typedef struct packed {
        logic       wb;
        logic [4:0] rd;
    } trk_t;
    fifo_t           fifo_q [DEPTH];
    fifo_t           fifo_d [DEPTH];
    trk_t            trk_q  [MAX_OUTST];
    trk_t            trk_d  [MAX_OUTST];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   twr_q, twr_d, trd_q, trd_d;
    logic [TCW-1:0]  tcnt_q, tcnt_d;
    state_e          state_q, state_d;
    logic            illegal_q, illegal_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_err_q, wb_err_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            proto_err_q, proto_err_d;
    logic            is_vec, accept, push, issue, rsp_pop;
    fifo_t           head;
    trk_t            thead;
    assign head  = fifo_q[rd_q];
    assign thead = trk_q[trd_q];
    assign is_vec = (id_instr_i[6:0] == 7'h07) || (id_instr_i[6:0] == 7'h27) ||
                    (id_instr_i[6:0] == 7'h57);
    assign id_ready_o     = (cnt_q < CW'(DEPTH)) && (state_q == IDLE) && !flush_i;
    assign accept         = id_valid_i && id_ready_o;
    assign push           = accept && is_vec;
    // Flush suppresses the request in its own cycle so a dropped entry can never be issued.
    assign vu_req_valid_o = (cnt_q != '0) && (tcnt_q < TCW'(MAX_OUTST)) && !flush_i;
    assign issue          = vu_req_valid_o && vu_req_ready_i;
    // A response with nothing outstanding is ignored apart from flagging the protocol error.
    assign rsp_pop        = vu_rsp_valid_i && (tcnt_q != '0);
    assign vu_instr_o     = head.instr;
    assign vu_rs1_o       = head.rs1;
    assign vu_rs2_o       = head.rs2;
    assign illegal_o      = illegal_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_err_o       = wb_err_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_data_o      = wb_data_q;
    assign proto_err_o    = proto_err_q;
    assign busy_o         = (cnt_q != '0) || (tcnt_q != '0);
    always_comb begin
        fifo_d = fifo_q;
        trk_d  = trk_q;
        if (push) fifo_d[wr_q] = {id_instr_i, id_rs1_i, id_rs2_i, id_wb_i};
        if (issue) trk_d[twr_q] = {head.wb, head.instr[11:7]};
        wr_d   = push ? wr_q + 1'b1 : wr_q;
        rd_d   = flush_i ? wr_q : (issue ? rd_q + 1'b1 : rd_q);
        cnt_d  = flush_i ? '0 : cnt_q + CW'(push) - CW'(issue);
        twr_d  = issue ? twr_q + 1'b1 : twr_q;
        trd_d  = rsp_pop ? trd_q + 1'b1 : trd_q;
        tcnt_d = tcnt_q + TCW'(issue) - TCW'(rsp_pop);
        // Intake stops in WB_WAIT, so the wb instr is always the youngest entry: a non-empty
        // FIFO at flush time means it is still un-issued and gets dropped with the rest.
        state_d = (state_q == IDLE) ? ((push && id_wb_i) ? WB_WAIT : IDLE)
                : (((flush_i && cnt_q != '0) || (rsp_pop && thead.wb)) ? IDLE : WB_WAIT);
        illegal_d   = accept && !is_vec;
        wb_valid_d  = rsp_pop && thead.wb && !vu_rsp_err_i;
        wb_err_d    = rsp_pop && vu_rsp_err_i;
        wb_rd_d     = rsp_pop ? thead.rd : wb_rd_q;
        wb_data_d   = rsp_pop ? vu_rsp_data_i : wb_data_q;
        proto_err_d = proto_err_q || (vu_rsp_valid_i && tcnt_q == '0);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q      <= '{default: '0};
            trk_q       <= '{default: '0};
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            twr_q       <= '0;
            trd_q       <= '0;
            tcnt_q      <= '0;
            state_q     <= IDLE;
            illegal_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_err_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            trk_q       <= trk_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            twr_q       <= twr_d;
            trd_q       <= trd_d;
            tcnt_q      <= tcnt_d;
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            wb_valid_q  <= wb_valid_d;
            wb_err_q    <= wb_err_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule
